// File: rtl/pcm_mic_capture.sv
// pcm_mic_capture
// ---------------
// Front end of the PCM microphone path. Generates the PDM bit clock, samples
// the 1-bit PDM stream through a 2-flop synchronizer, counts ones over a
// window of DEC bits and pushes each 8-bit count into the downstream sample
// FIFO with a single-cycle write strobe. A sample is dropped, and overrun is
// set, when the FIFO reports full during the push cycle.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   enable    in   capture enable (level)
//   mic_data  in   PDM data, asynchronous to clock
//   mic_clk   out  PDM bit clock (registered), period 2*CLK_DIV clocks
//   mic_lrsel out  channel select, tied to left (0)
//   dout      out  PCM sample (number of ones in the last window)
//   wr        out  FIFO write strobe, one clock wide, never while full=1
//   full      in   FIFO full flag, only looked at in the push cycle
//   overrun   out  sticky flag: a sample was dropped because of full
module pcm_mic_capture #(
    parameter int CLK_DIV = 50,
    parameter int DEC     = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       mic_data,
    output logic       mic_clk,
    output logic       mic_lrsel,
    output logic [7:0] dout,
    output logic       wr,
    input  logic       full,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [7:0] DEC_LAST = 8'(DEC - 1);

    state_t     state_r, state_n_s;
    logic       sync1_r, sync_d_r;
    logic [9:0] div_cnt_r, div_cnt_n_s;
    logic       mic_clk_r, mic_clk_n_s;
    logic [7:0] bit_cnt_r, bit_cnt_n_s;
    logic [7:0] ones_cnt_r, ones_cnt_n_s;
    logic [7:0] dout_r, dout_n_s;
    logic       overrun_r, overrun_n_s;
    logic       wr_s;
    logic       sample_s;

    // Two-flop synchronizer for the asynchronous PDM input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 1'b0;
            sync_d_r <= 1'b0;
        end else begin
            sync1_r  <= mic_data;
            sync_d_r <= sync1_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= 10'd0;
            mic_clk_r  <= 1'b0;
            bit_cnt_r  <= 8'd0;
            ones_cnt_r <= 8'd0;
            dout_r     <= 8'd0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            div_cnt_r  <= div_cnt_n_s;
            mic_clk_r  <= mic_clk_n_s;
            bit_cnt_r  <= bit_cnt_n_s;
            ones_cnt_r <= ones_cnt_n_s;
            dout_r     <= dout_n_s;
            overrun_r  <= overrun_n_s;
        end
    end

    // Next-state, divider, decimation counters and the write strobe.
    always_comb begin
        state_n_s    = state_r;
        div_cnt_n_s  = div_cnt_r;
        mic_clk_n_s  = mic_clk_r;
        bit_cnt_n_s  = bit_cnt_r;
        ones_cnt_n_s = ones_cnt_r;
        dout_n_s     = dout_r;
        overrun_n_s  = overrun_r;
        wr_s         = 1'b0;
        // Data is valid while mic_clk is high; we take it as mic_clk falls.
        // The push cycle can never coincide with a falling edge (CLK_DIV>=2).
        sample_s     = (state_r == ST_RUN) && mic_clk_r && (div_cnt_r == DIV_LAST);

        case (state_r)
            ST_IDLE: begin
                div_cnt_n_s  = 10'd0;
                mic_clk_n_s  = 1'b0;
                bit_cnt_n_s  = 8'd0;
                ones_cnt_n_s = 8'd0;
                if (enable) begin
                    state_n_s   = ST_RUN;
                    overrun_n_s = 1'b0;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN, ST_PUSH: begin
                // A pending push always completes, even if enable just dropped.
                if (state_r == ST_PUSH) begin
                    if (full) begin
                        overrun_n_s = 1'b1;
                    end else begin
                        wr_s = 1'b1;
                    end
                end else begin
                    wr_s = 1'b0;
                end

                if (!enable) begin
                    // Abandon the partial window; dout and overrun keep their values.
                    state_n_s    = ST_IDLE;
                    div_cnt_n_s  = 10'd0;
                    mic_clk_n_s  = 1'b0;
                    bit_cnt_n_s  = 8'd0;
                    ones_cnt_n_s = 8'd0;
                end else begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_n_s = 10'd0;
                        mic_clk_n_s = ~mic_clk_r;
                    end else begin
                        div_cnt_n_s = div_cnt_r + 10'd1;
                    end

                    if (sample_s) begin
                        if (bit_cnt_r == DEC_LAST) begin
                            // Window complete: the final bit is included in the sample.
                            dout_n_s     = ones_cnt_r + {7'd0, sync_d_r};
                            bit_cnt_n_s  = 8'd0;
                            ones_cnt_n_s = 8'd0;
                            state_n_s    = ST_PUSH;
                        end else begin
                            bit_cnt_n_s  = bit_cnt_r + 8'd1;
                            ones_cnt_n_s = ones_cnt_r + {7'd0, sync_d_r};
                            state_n_s    = ST_RUN;
                        end
                    end else begin
                        state_n_s = ST_RUN;
                    end
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // wr follows full combinationally so it can never be high alongside full.
    assign wr        = wr_s;
    assign mic_clk   = mic_clk_r;
    assign mic_lrsel = 1'b0;
    assign dout      = dout_r;
    assign overrun   = overrun_r;

endmodule
